// File: rtl/spi_fifo_tx.sv
`timescale 1ns/1ps
// SPI slave (mode 0) transmit engine: pops bytes from a FWFT FIFO and shifts them out MSB-first.
// Optional saturating underrun counter enabled with SPI_FIFO_TX_UNDERRUN_CNT_EN.
//
// state | meaning
// IDLE  | chip select high, waiting for CSn falling edge
// LOAD  | one cycle: fetch FIFO head (or FILL on empty) into the shift register
// SHIFT | serialising the byte, counting SCK rising edges
module spi_fifo_tx #(
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sck,
  input  logic       i_csn,
  input  logic       i_empty,
  input  logic [7:0] i_data,
  output logic       o_rd,
  output logic       o_miso,
  output logic       o_busy,
  output logic       o_underrun
`ifdef SPI_FIFO_TX_UNDERRUN_CNT_EN
  ,output logic [7:0] o_underrun_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t     state_q, state_d;
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] csn_sync_q, csn_sync_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic load_go;

  // Stage [1] is the synchronised level, stage [2] its previous value.
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall  = ~csn_sync_q[1] & csn_sync_q[2];
  assign cs_rise  = csn_sync_q[1] & ~csn_sync_q[2];

  // A chip-select release in LOAD cancels the fetch entirely.
  assign load_go    = (state_q == LOAD) & ~cs_rise;
  assign o_rd       = load_go & ~i_empty;
  assign o_underrun = load_go & i_empty;
  assign o_miso     = shreg_q[7];
  assign o_busy     = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    sck_sync_d  = {sck_sync_q[1:0], i_sck};
    csn_sync_d  = {csn_sync_q[1:0], i_csn};

    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        bit_cnt_d   = 3'd0;
        byte_done_d = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
        end else begin
          shreg_d = i_empty ? FILL : i_data;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          byte_done_d = 1'b0;
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
        end else if (sck_fall) begin
          if (byte_done_q) state_d = LOAD;
          else             shreg_d = {shreg_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      sck_sync_q  <= 3'b000;
      csn_sync_q  <= 3'b111;
      shreg_q     <= FILL;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      csn_sync_q  <= csn_sync_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
    end
  end

`ifdef SPI_FIFO_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (o_underrun && (underrun_cnt_q != 8'hFF)) underrun_cnt_d = underrun_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) underrun_cnt_q <= 8'd0;
    else         underrun_cnt_q <= underrun_cnt_d;
  end

  assign o_underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_spi_fifo_tx.sv
`timescale 1ns/1ps
// Bench for spi_fifo_tx: behavioural FWFT FIFO, SPI mode-0 master, and a queue of expected bytes.
module tb_spi_fifo_tx;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_sck;
  logic       i_csn;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       o_rd, o_miso, o_busy, o_underrun;
`ifdef SPI_FIFO_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  spi_fifo_tx #(.FILL(8'hFF)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sck      (i_sck),
    .i_csn      (i_csn),
    .i_empty    (fifo_empty),
    .i_data     (fifo_head),
    .o_rd       (o_rd),
    .o_miso     (o_miso),
    .o_busy     (o_busy),
`ifdef SPI_FIFO_TX_UNDERRUN_CNT_EN
    .o_underrun_cnt (underrun_cnt),
`endif
    .o_underrun (o_underrun)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int und_cnt  = 0;

  function automatic void fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_head  = fifo_empty ? 8'h00 : fifo_q[0];
  endfunction

  task automatic fifo_push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_refresh();
  endtask

  // FIFO model: pop takes effect just after the clock edge that ends the o_rd cycle.
  always @(negedge i_clk) begin
    if (o_rd === 1'b1) begin
      rd_cnt++;
      n_checks++;
      if (fifo_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_while_empty: empty=%b required 0 at %0t", fifo_empty, $time);
      end
      @(posedge i_clk);
      #1;
      if (fifo_q.size() > 0) fifo_q.delete(0);
      fifo_refresh();
    end
  end

  always @(negedge i_clk) if (o_underrun === 1'b1) und_cnt++;

  task automatic spi_bits(input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      repeat (5) @(negedge i_clk);
      i_sck = 1'b1;
      got = {got[6:0], o_miso};
      repeat (5) @(negedge i_clk);
      i_sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    @(negedge i_clk);
    i_csn = 1'b0;
    repeat (8) @(negedge i_clk);
  endtask

  task automatic cs_end();
    repeat (6) @(negedge i_clk);
    i_csn = 1'b1;
    repeat (8) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_csn   = 1'b1;
    i_sck   = 1'b0;
    fifo_refresh();
    repeat (3) @(negedge i_clk);
    #1;
    n_checks++; if (o_miso !== 1'b1)     begin n_fail++; $display("FAIL reset_miso: got %b required 1", o_miso); end
    n_checks++; if (o_rd !== 1'b0)       begin n_fail++; $display("FAIL reset_rd: got %b required 0", o_rd); end
    n_checks++; if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    n_checks++; if (o_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b required 0", o_underrun); end
`ifdef SPI_FIFO_TX_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %h required 00", underrun_cnt); end
`endif
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clk);
  endtask

  task automatic test_two_bytes();
    logic [7:0] got, exp_b;
    int rd0;
    rd0 = rd_cnt;
    fifo_push(8'hA5); exp_q.push_back(8'hA5);
    fifo_push(8'h3C); exp_q.push_back(8'h3C);
    @(negedge i_clk);
    i_csn = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    n_checks++; if (o_rd !== 1'b0) begin n_fail++; $display("FAIL pop_latency_early: got %b required 0", o_rd); end
    @(negedge i_clk);
    n_checks++; if (o_rd !== 1'b1) begin n_fail++; $display("FAIL pop_latency: got %b required 1", o_rd); end
    repeat (5) @(negedge i_clk);
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b required 1", o_busy); end
    for (int b = 0; b < 2; b++) begin
      spi_bits(8, got);
      exp_b = exp_q.pop_front();
      n_checks++;
      if (got !== exp_b) begin n_fail++; $display("FAIL two_bytes_data%0d: got %h required %h", b, got, exp_b); end
    end
    cs_end();
    n_checks++; if (rd_cnt - rd0 != 2) begin n_fail++; $display("FAIL two_bytes_rd_cnt: got %0d required 2", rd_cnt - rd0); end
    n_checks++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL two_bytes_busy_end: got %b required 0", o_busy); end
  endtask

  task automatic test_underrun();
    logic [7:0] got, exp_b;
    int rd0, un0;
    rd0 = rd_cnt; un0 = und_cnt;
    exp_q.push_back(8'hFF);
    cs_start();
    spi_bits(8, got);
    exp_b = exp_q.pop_front();
    n_checks++; if (got !== exp_b) begin n_fail++; $display("FAIL underrun_data: got %h required %h", got, exp_b); end
    cs_end();
    n_checks++; if (und_cnt - un0 != 2) begin n_fail++; $display("FAIL underrun_pulses: got %0d required 2", und_cnt - un0); end
    n_checks++; if (rd_cnt - rd0 != 0)  begin n_fail++; $display("FAIL underrun_no_rd: got %0d required 0", rd_cnt - rd0); end
  endtask

  task automatic test_abort();
    logic [7:0] got, exp_b;
    int rd0;
    rd0 = rd_cnt;
    fifo_push(8'h81);
    cs_start();
    spi_bits(3, got);
    n_checks++; if (got[2:0] !== 3'b100) begin n_fail++; $display("FAIL abort_bits: got %b required 100", got[2:0]); end
    repeat (2) @(negedge i_clk);
    i_csn = 1'b1;
    repeat (8) @(negedge i_clk);
    n_checks++; if (o_busy !== 1'b0)    begin n_fail++; $display("FAIL abort_idle: got %b required 0", o_busy); end
    n_checks++; if (rd_cnt - rd0 != 1)  begin n_fail++; $display("FAIL abort_rd_cnt: got %0d required 1", rd_cnt - rd0); end
    fifo_push(8'h42); exp_q.push_back(8'h42);
    cs_start();
    spi_bits(8, got);
    exp_b = exp_q.pop_front();
    n_checks++; if (got !== exp_b) begin n_fail++; $display("FAIL abort_next_frame: got %h required %h", got, exp_b); end
    cs_end();
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, exp_b;
    int rd0;
    fifo_push(8'h0F);
    fifo_push(8'h33); exp_q.push_back(8'h33);
    cs_start();
    spi_bits(2, got);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    n_checks++; if (o_miso !== 1'b1) begin n_fail++; $display("FAIL midreset_miso: got %b required 1", o_miso); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", o_busy); end
    n_checks++; if (o_rd !== 1'b0)   begin n_fail++; $display("FAIL midreset_rd: got %b required 0", o_rd); end
    i_csn = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    rd0 = rd_cnt;
    repeat (12) @(negedge i_clk);
    n_checks++; if (rd_cnt != rd0)   begin n_fail++; $display("FAIL midreset_no_pop: got %0d pops required 0", rd_cnt - rd0); end
    cs_start();
    spi_bits(8, got);
    exp_b = exp_q.pop_front();
    n_checks++; if (got !== exp_b) begin n_fail++; $display("FAIL midreset_next_frame: got %h required %h", got, exp_b); end
    cs_end();
  endtask

  task automatic test_late_push();
    logic [7:0] got, part, exp_b;
    int rd0;
    rd0 = rd_cnt;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h5A);
    cs_start();
    spi_bits(3, part);
    fifo_push(8'h5A);
    spi_bits(5, got);
    got = {part[2:0], got[4:0]};
    exp_b = exp_q.pop_front();
    n_checks++; if (got !== exp_b) begin n_fail++; $display("FAIL late_push_byte1: got %h required %h", got, exp_b); end
    spi_bits(8, got);
    exp_b = exp_q.pop_front();
    n_checks++; if (got !== exp_b) begin n_fail++; $display("FAIL late_push_byte2: got %h required %h", got, exp_b); end
    cs_end();
    n_checks++; if (rd_cnt - rd0 != 1) begin n_fail++; $display("FAIL late_push_rd_cnt: got %0d required 1", rd_cnt - rd0); end
  endtask

`ifdef SPI_FIFO_TX_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    logic [7:0] got;
    int bad;
    bad = 0;
    cs_start();
    for (int i = 0; i < 300; i++) begin
      spi_bits(8, got);
      if (got !== 8'hFF) bad++;
    end
    cs_end();
    n_checks++; if (bad != 0)              begin n_fail++; $display("FAIL cnt_fill_bytes: got %0d bad bytes required 0", bad); end
    n_checks++; if (underrun_cnt !== 8'hFF) begin n_fail++; $display("FAIL cnt_saturate: got %h required ff", underrun_cnt); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_bytes();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_late_push();
`ifdef SPI_FIFO_TX_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
